ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries and maximum outstanding memory reads (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  output  1  memory read request valid.
REQ-006 SHALL have port req_ready  input  1  memory accepts request.
REQ-007 SHALL have port req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port rsp_valid  input  1  read data returned (in order, no back-pressure).
REQ-009 SHALL have port rsp_data  input  32  instruction word.
REQ-010 SHALL have port rsp_err  input  1  access fault, qualified by rsp_valid.
REQ-011 SHALL have ports inst_valid output 1, inst_ready input 1, inst output 32, inst_pc output 32: instruction handoff to the execute core.
REQ-012 SHALL have ports redirect_valid input 1, redirect_pc input 32: jal/jalr target from the core.
REQ-013 SHALL have port fetch_err  output  1  sticky fault flag.

Function
REQ-014 SHALL implement states RUN, STALL, HALT; STALL when outstanding+occupancy == DEPTH, else RUN; HALT on accepted rsp_err.
REQ-015 SHALL assert req_valid in RUN only, with req_addr = fetch_pc; req_valid SHALL be low in any cycle redirect_valid is high.
REQ-016 SHALL advance fetch_pc by 4 on req_valid && req_ready, wrapping modulo 2^32.
REQ-017 SHALL hold req_addr stable while req_valid && !req_ready.
REQ-018 SHALL push {rsp_data, issuing pc} into the buffer on rsp_valid unless the response is marked for discard; the credit rule guarantees no overflow.
REQ-019 SHALL drive inst_valid = buffer non-empty; inst/inst_pc = head entry; pop on inst_valid && inst_ready; first instruction visible earliest one cycle after rsp_valid.
REQ-020 SHALL on redirect_valid: flush buffer, load fetch_pc = {redirect_pc[31:2],2'b00} next cycle, and set drop count = responses still in flight.
REQ-021 SHALL discard responses while drop count > 0, decrementing per rsp_valid; a response arriving in the redirect cycle is itself discarded.
REQ-022 SHALL give redirect priority over a same-cycle pop and push.
REQ-023 SHALL on rsp_err (non-discarded) enter HALT, set fetch_err, not push the entry, deassert req_valid; buffered entries remain poppable; redirect ignored in HALT.
REQ-024 SHALL ignore rsp_err on discarded responses.

Reset
REQ-025 SHALL on reset low, asynchronously: state RUN, fetch_pc = RESET_PC, buffer empty, outstanding = 0, drop = 0, req_valid = 0, inst_valid = 0, fetch_err = 0, inst/inst_pc = 0.
REQ-026 SHALL abandon in-flight reads on reset; memory side is reset concurrently.
REQ-027 SHALL issue first request at RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL with IFU_PERF_CNT_EN defined add outputs perf_fetched (32) counting popped instructions and perf_flushed (32) counting discarded/flushed words, both wrapping, reset to 0.
REQ-029 SHALL without IFU_PERF_CNT_EN have neither port nor counter logic.

Structure
REQ-030 SHALL place RESET_PC default, state enum and buffer entry struct {inst, pc} in package ifu_pkg.
REQ-031 SHALL implement the buffer as sub-module ifu_fifo (DEPTH entries, push/pop/flush, count).

Verification
REQ-032 Reset release, req_ready=1, 1-cycle memory returning 32'h00000413 -> first req_addr 8000_0000, inst_valid next cycle with inst_pc 8000_0000, then 8000_0004.
REQ-033 inst_ready=0 for 10 cycles -> exactly DEPTH requests issued, req_valid low until pop.
REQ-034 redirect_pc 8000_0102 with 2 reads in flight -> both responses dropped, next req_addr 8000_0100, inst_valid low until new data.
REQ-035 req_ready=0 for 3 cycles -> req_addr constant 8000_0000, fetch_pc not advanced.
REQ-036 rsp_err on third response -> fetch_err=1, two prior instructions delivered, no further requests until reset.
REQ-037 fetch_pc FFFF_FFFC -> next req_addr 0000_0000.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and defaults for the instruction fetch unit.
`default_nettype none

package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifu_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ifu_fifo: DEPTH-entry instruction buffer with push/pop/flush and occupancy count.
`default_nettype none

module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [31:0]   push_inst_i,
    input  logic [31:0]   push_pc_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [31:0]   head_inst_o,
    output logic [31:0]   head_pc_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    ifu_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{inst: push_inst_i, pc: push_pc_i};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_inst_o = mem_q[rd_ptr_q].inst;
    assign head_pc_o   = mem_q[rd_ptr_q].pc;
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ifu_fetch: credit-based in-order instruction fetch with redirect and fault halt.
// Optional IFU_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
`default_nettype none

module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    ifu_state_e    state_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          err_q;

    logic          halted, redir, discard, push, halt_set, issue, pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt, cnt_d;
    logic [CW-1:0] rsp_ext, issue_ext, push_ext, pop_ext;
    logic [CW:0]   credit_used_d;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign halted   = (state_q == HALT);
    assign redir    = redirect_valid && !halted;
    // Everything returning during a redirect, while draining, or after a halt is dropped.
    assign discard  = redir || (drop_q != '0) || halted;
    assign push     = rsp_valid && !discard && !rsp_err;
    assign halt_set = rsp_valid && !discard && rsp_err;

    assign req_valid  = (state_q == RUN) && !redirect_valid && reset;
    assign req_addr   = fetch_pc_q;
    assign issue      = req_valid && req_ready;
    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && inst_ready && !redir;
    assign fetch_err  = err_q;

    assign rsp_ext   = {{(CW-1){1'b0}}, rsp_valid};
    assign issue_ext = {{(CW-1){1'b0}}, issue};
    assign push_ext  = {{(CW-1){1'b0}}, push};
    assign pop_ext   = {{(CW-1){1'b0}}, pop};

    always_comb begin
        out_d         = out_q + issue_ext - rsp_ext;
        cnt_d         = redir ? '0 : (fifo_cnt + push_ext - pop_ext);
        credit_used_d = {1'b0, out_d} + {1'b0, cnt_d};

        drop_d = drop_q;
        if (redir) begin
            drop_d = out_q - rsp_ext;
        end else if (rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        if (redir) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            case (state_q)
                RUN, STALL: begin
                    if (halt_set) begin
                        state_q <= HALT;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= (credit_used_d >= DEPTH_C) ? STALL : RUN;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= RUN;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push),
        .push_inst_i(rsp_data),
        .push_pc_i  (fetch_pc_q - {out_q, 2'b00}),
        .pop_i      (pop),
        .flush_i    (redir),
        .head_inst_o(inst),
        .head_pc_o  (inst_pc),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] flushed_words;

    assign flushed_words = (redir ? 32'(fifo_cnt) : 32'd0) + {31'd0, rsp_valid && discard};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, pop};
            perf_flushed_q <= perf_flushed_q + flushed_words;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

`default_nettype wire
